// File: rtl/bloom_filter_rmw.sv
// bloom_filter_rmw
//   Front end of a time-bucketed counting Bloom filter held in SRAM.
//   Each request carries NUM_HASHES word indices. Every index gets a full
//   read-modify-write before the next index is read. Inserts increment the
//   current bucket, saturating at its maximum. Removes decrement the newest
//   non-zero bucket and report whether every index found one.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   in_wr/in_is_ack   request strobe (only while in_rdy) / 1=remove, 0=insert
//   in_index          NUM_HASHES packed indices, hash h at [h*AW +: AW]
//   in_rdy            request FIFO not full
//   rotate            pulse: advance cur_bucket at the next idle point
//   cur_bucket        current bucket pointer
//   rotate_ovf        sticky: a rotate arrived while one was still pending
//   res_vld/res_hit   one-cycle result of a completed remove
//   rd_req/rd_addr    SRAM read, held until rd_ack; data returns with rd_vld
//   wr_req/wr_addr/wr_data  SRAM write, held until wr_ack
module bloom_filter_rmw #(
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 72,
    parameter int BITSBUCKET      = 4,
    parameter int NUM_BUCKETS     = 12,
    parameter int NUM_HASHES      = 2,
    parameter int FIFO_DEPTH_BITS = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_wr,
    input  logic                                  in_is_ack,
    input  logic [NUM_HASHES*SRAM_ADDR_WIDTH-1:0] in_index,
    output logic                                  in_rdy,
    input  logic                                  rotate,
    output logic [$clog2(NUM_BUCKETS)-1:0]        cur_bucket,
    output logic                                  rotate_ovf,
    output logic                                  res_vld,
    output logic                                  res_hit,
    output logic                                  rd_req,
    output logic [SRAM_ADDR_WIDTH-1:0]            rd_addr,
    input  logic                                  rd_ack,
    input  logic                                  rd_vld,
    input  logic [SRAM_DATA_WIDTH-1:0]            rd_data,
    output logic                                  wr_req,
    output logic [SRAM_ADDR_WIDTH-1:0]            wr_addr,
    output logic [SRAM_DATA_WIDTH-1:0]            wr_data,
    input  logic                                  wr_ack
);

    // state   | meaning
    // IDLE    | apply a pending rotate, else pop the next request
    // RD_REQ  | read request for index h, held until rd_ack
    // RD_WAIT | waiting for rd_vld, word captured on arrival
    // MODIFY  | update the captured word (one cycle)
    // WR_REQ  | write back index h, held until wr_ack
    // DONE    | report a remove result, back to IDLE

    localparam int AW    = SRAM_ADDR_WIDTH;
    localparam int DW    = SRAM_DATA_WIDTH;
    localparam int BB    = BITSBUCKET;
    localparam int NB    = NUM_BUCKETS;
    localparam int NH    = NUM_HASHES;
    localparam int CBW   = $clog2(NUM_BUCKETS);
    localparam int HW    = (NUM_HASHES > 1) ? $clog2(NUM_HASHES) : 1;
    localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
    localparam int EW    = 1 + NH * AW;

    localparam logic [FIFO_DEPTH_BITS:0] FIFO_FULL   = DEPTH[FIFO_DEPTH_BITS:0];
    localparam logic [CBW-1:0]           LAST_BUCKET = CBW'(NB - 1);
    localparam logic [HW-1:0]            LAST_HASH   = HW'(NH - 1);

    generate
        if (NB * BB > DW) begin : g_bad_cfg
            $error("bloom_filter_rmw: NUM_BUCKETS*BITSBUCKET exceeds SRAM_DATA_WIDTH");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, MODIFY, WR_REQ, DONE
    } state_t;

    state_t              state;
    logic                rot_pend;
    logic                ent_is_ack;
    logic [NH*AW-1:0]    ent_idx;
    logic [HW-1:0]       h;
    logic                hit_acc;
    logic [DW-1:0]       word;

    // Request FIFO (fallthrough: head is visible as soon as count != 0).
    // A write while full is simply dropped.
    logic [EW-1:0]              fifo_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] fifo_wptr;
    logic [FIFO_DEPTH_BITS-1:0] fifo_rptr;
    logic [FIFO_DEPTH_BITS:0]   fifo_cnt;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_empty;
    logic [EW-1:0]              fifo_head;

    assign fifo_empty = (fifo_cnt == '0);
    assign in_rdy     = (fifo_cnt != FIFO_FULL);
    assign fifo_push  = in_wr && in_rdy;
    // A pending rotate takes priority over popping a new request
    assign fifo_pop   = (state == IDLE) && !rot_pend && !fifo_empty;
    assign fifo_head  = fifo_mem[fifo_rptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_wptr <= '0;
            fifo_rptr <= '0;
            fifo_cnt  <= '0;
        end else begin
            if (fifo_push) begin
                fifo_mem[fifo_wptr] <= {in_is_ack, in_index};
                fifo_wptr           <= fifo_wptr + 1'b1;
            end
            if (fifo_pop)
                fifo_rptr <= fifo_rptr + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Word update. Inserts touch only the current bucket; removes walk
    // backwards in time from the current bucket to the first non-zero one.
    logic [DW-1:0] mod_word;
    logic          mod_found;

    always_comb begin
        int srch;
        srch      = 0;
        mod_word  = word;
        mod_found = 1'b0;
        if (!ent_is_ack) begin
            mod_found = 1'b1;
            if (word[int'(cur_bucket)*BB +: BB] != {BB{1'b1}})
                mod_word[int'(cur_bucket)*BB +: BB] = word[int'(cur_bucket)*BB +: BB] + 1'b1;
        end else begin
            for (int k = 0; k < NB; k++) begin
                srch = (int'(cur_bucket) + NB - k) % NB;
                if (!mod_found && (word[srch*BB +: BB] != '0)) begin
                    mod_word[srch*BB +: BB] = word[srch*BB +: BB] - 1'b1;
                    mod_found               = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur_bucket <= '0;
            rot_pend   <= 1'b0;
            rotate_ovf <= 1'b0;
            ent_is_ack <= 1'b0;
            ent_idx    <= '0;
            h          <= '0;
            hit_acc    <= 1'b0;
            word       <= '0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            wr_req     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            res_vld    <= 1'b0;
            res_hit    <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            res_hit <= 1'b0;

            if (rotate && rot_pend)
                rotate_ovf <= 1'b1;
            else if (rotate)
                rot_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (rot_pend) begin
                        cur_bucket <= (cur_bucket == LAST_BUCKET) ? '0 : cur_bucket + 1'b1;
                        rot_pend   <= 1'b0;
                    end else if (!fifo_empty) begin
                        ent_is_ack <= fifo_head[EW-1];
                        ent_idx    <= fifo_head[EW-2:0];
                        h          <= '0;
                        hit_acc    <= 1'b1;
                        rd_req     <= 1'b1;
                        rd_addr    <= fifo_head[AW-1:0];
                        state      <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (rd_ack) begin
                        rd_req <= 1'b0;
                        state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_vld) begin
                        word  <= rd_data;
                        state <= MODIFY;
                    end
                end
                MODIFY: begin
                    word    <= mod_word;
                    hit_acc <= hit_acc & mod_found;
                    wr_req  <= 1'b1;
                    wr_addr <= ent_idx[int'(h)*AW +: AW];
                    wr_data <= mod_word;
                    state   <= WR_REQ;
                end
                WR_REQ: begin
                    if (wr_ack) begin
                        wr_req <= 1'b0;
                        if (h != LAST_HASH) begin
                            h       <= h + 1'b1;
                            rd_req  <= 1'b1;
                            rd_addr <= ent_idx[(int'(h) + 1)*AW +: AW];
                            state   <= RD_REQ;
                        end else begin
                            // res_vld is visible during DONE
                            res_vld <= ent_is_ack;
                            res_hit <= ent_is_ack & hit_acc;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
